// File: rtl/scr_pkg.sv
// Shared definitions for the scramble sequencer: FSM state encoding,
// index geometry and the mode to move-count mapping.
package scr_pkg;

    localparam int IDX_W     = 3;
    localparam int NUM_IDX   = 6;
    localparam int MOVES_W   = IDX_W * NUM_IDX;
    localparam int NUM_FACES = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KICK,
        ST_WAIT,
        ST_CHECK,
        ST_RESULT
    } state_t;

    // Mode 00..11 maps to 3..6 meaningful moves.
    function automatic logic [2:0] mode_to_count(input logic [1:0] mode);
        return {1'b0, mode} + 3'd3;
    endfunction

endpackage

// File: rtl/scr_seq_checker.sv
// Combinational validator for a captured move list. Only the first
// move_count indices are examined; each must name a legal face.
// Build option SCR_SEQ_ADJ_CHECK_EN additionally rejects any adjacent
// pair of equal indices among the used slots.
module scr_seq_checker
    import scr_pkg::*;
(
    input  logic [MOVES_W-1:0] i_capture,
    input  logic [2:0]         i_move_count,
    output logic               o_ok
);

    localparam logic [IDX_W-1:0] FACE_LIM = IDX_W'(NUM_FACES);

    // Scan the used slots and clear ok on the first rule violation.
    always_comb begin
        // NOTE: o_ok gets its default before any conditional write, so no latch is inferred.
        o_ok = 1'b1;
        for (int k = 0; k < NUM_IDX; k++) begin
            if (k < int'(i_move_count)) begin
                if (i_capture[k*IDX_W +: IDX_W] >= FACE_LIM) begin
                    o_ok = 1'b0;
                end
            end
        end
`ifdef SCR_SEQ_ADJ_CHECK_EN
        for (int k = 0; k < NUM_IDX - 1; k++) begin
            if (k + 1 < int'(i_move_count)) begin
                if (i_capture[k*IDX_W +: IDX_W] == i_capture[(k+1)*IDX_W +: IDX_W]) begin
                    o_ok = 1'b0;
                end
            end
        end
`endif
    end

endmodule

// File: rtl/scramble_sequencer.sv
// Sequences one scramble request: kick the RNG, wait (with timeout) for
// the datapath, validate the six indices, retry on bad or missing
// results, then hold the accepted move list until the consumer acks.
// Optional adjacency rejection: define SCR_SEQ_ADJ_CHECK_EN.
module scramble_sequencer
    import scr_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int MAX_RETRY   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic               ack,
    input  logic               scr_done,
    input  logic [IDX_W-1:0]   scr_idx1,
    input  logic [IDX_W-1:0]   scr_idx2,
    input  logic [IDX_W-1:0]   scr_idx3,
    input  logic [IDX_W-1:0]   scr_idx4,
    input  logic [IDX_W-1:0]   scr_idx5,
    input  logic [IDX_W-1:0]   scr_idx6,
    output logic               rng_gen,
    output logic [1:0]         scr_mode,
    output logic               busy,
    output logic               valid,
    output logic               fail,
    output logic [MOVES_W-1:0] moves,
    output logic [2:0]         move_count,
    output logic [1:0]         retries
);

    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_CYC);
    localparam logic [1:0] RETRY_LIM = 2'(MAX_RETRY);

    state_t             r_state,  w_state_nxt;
    logic [7:0]         r_cnt,    w_cnt_nxt;
    logic [MOVES_W-1:0] r_capture;
    logic [MOVES_W-1:0] r_moves,  w_moves_nxt;
    logic [2:0]         r_move_count, w_move_count_nxt;
    logic [1:0]         r_retries, w_retries_nxt;
    logic [1:0]         r_scr_mode, w_scr_mode_nxt;
    logic               r_valid,  w_valid_nxt;
    logic               r_fail,   w_fail_nxt;

    logic               w_capture_load;
    logic               w_retry;
    logic               w_ok;
    logic [MOVES_W-1:0] w_idx_bus;
    logic [MOVES_W-1:0] w_used_mask;

    assign w_idx_bus = {scr_idx6, scr_idx5, scr_idx4, scr_idx3, scr_idx2, scr_idx1};

    scr_seq_checker u_checker (
        .i_capture    (r_capture),
        .i_move_count (r_move_count),
        .o_ok         (w_ok)
    );

    // Keep only the slots that belong to the current move count.
    always_comb begin
        w_used_mask = '0;
        for (int k = 0; k < NUM_IDX; k++) begin
            if (k < int'(r_move_count)) begin
                w_used_mask[k*IDX_W +: IDX_W] = '1;
            end
        end
    end

    // Next-state and next-register decode, with the shared retry path last.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_moves_nxt      = r_moves;
        w_move_count_nxt = r_move_count;
        w_retries_nxt    = r_retries;
        w_scr_mode_nxt   = r_scr_mode;
        w_valid_nxt      = r_valid;
        w_fail_nxt       = r_fail;
        w_capture_load   = 1'b0;
        w_retry          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start && !r_valid && !r_fail) begin
                    w_scr_mode_nxt   = mode;
                    w_move_count_nxt = mode_to_count(mode);
                    w_retries_nxt    = 2'd0;
                    w_moves_nxt      = '0;
                    w_state_nxt      = ST_KICK;
                end
            end
            ST_KICK: begin
                w_cnt_nxt   = 8'd0;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the expiry cycle still counts.
                if (scr_done) begin
                    w_capture_load = 1'b1;
                    w_state_nxt    = ST_CHECK;
                end else if (r_cnt == TO_LAST) begin
                    w_retry = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            ST_CHECK: begin
                if (w_ok) begin
                    w_moves_nxt = r_capture & w_used_mask;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_RESULT;
                end else begin
                    w_retry = 1'b1;
                end
            end
            ST_RESULT: begin
                if (ack) begin
                    w_valid_nxt = 1'b0;
                    w_fail_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_retry) begin
            if (r_retries < RETRY_LIM) begin
                w_retries_nxt = r_retries + 2'd1;
                w_state_nxt   = ST_KICK;
            end else begin
                w_fail_nxt  = 1'b1;
                w_moves_nxt = '0;
                w_state_nxt = ST_RESULT;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Control and result registers, all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= 8'd0;
            r_moves      <= '0;
            r_move_count <= 3'd0;
            r_retries    <= 2'd0;
            r_scr_mode   <= 2'd0;
            r_valid      <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_moves      <= w_moves_nxt;
            r_move_count <= w_move_count_nxt;
            r_retries    <= w_retries_nxt;
            r_scr_mode   <= w_scr_mode_nxt;
            r_valid      <= w_valid_nxt;
            r_fail       <= w_fail_nxt;
        end
    end

    // Capture the raw datapath indices when the datapath reports done.
    always_ff @(posedge clk) begin
        // NOTE: no reset here on purpose; the capture is only read in CHECK, right after a load.
        if (w_capture_load) begin
            r_capture <= w_idx_bus;
        end
    end

    assign rng_gen    = (r_state == ST_KICK);
    assign busy       = (r_state == ST_KICK) || (r_state == ST_WAIT) || (r_state == ST_CHECK);
    assign scr_mode   = r_scr_mode;
    assign valid      = r_valid;
    assign fail       = r_fail;
    assign moves      = r_moves;
    assign move_count = r_move_count;
    assign retries    = r_retries;

endmodule

// File: tb/tb_scramble_sequencer.sv
// Scoreboard bench for scramble_sequencer: directed requests push their
// expected result; a monitor pops and compares when valid or fail rises.
module tb_scramble_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        ack = 1'b0;
    logic        scr_done = 1'b0;
    logic [2:0]  scr_idx1 = 3'd0, scr_idx2 = 3'd0, scr_idx3 = 3'd0;
    logic [2:0]  scr_idx4 = 3'd0, scr_idx5 = 3'd0, scr_idx6 = 3'd0;
    logic        rng_gen, busy, valid, fail;
    logic [1:0]  scr_mode, retries;
    logic [17:0] moves;
    logic [2:0]  move_count;

    typedef struct {
        logic        valid;
        logic        fail;
        logic [17:0] moves;
        logic [2:0]  mc;
        logic [1:0]  retries;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   seen     = 1'b0;

    scramble_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .ack(ack),
        .scr_done(scr_done),
        .scr_idx1(scr_idx1), .scr_idx2(scr_idx2), .scr_idx3(scr_idx3),
        .scr_idx4(scr_idx4), .scr_idx5(scr_idx5), .scr_idx6(scr_idx6),
        .rng_gen(rng_gen), .scr_mode(scr_mode), .busy(busy),
        .valid(valid), .fail(fail), .moves(moves),
        .move_count(move_count), .retries(retries)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic v, input logic f, input logic [17:0] mv,
                            input logic [2:0] mc, input logic [1:0] rt);
        exp_t e;
        e.valid = v; e.fail = f; e.moves = mv; e.mc = mc; e.retries = rt;
        sb.push_back(e);
    endtask

    // Monitor: one comparison set per rising result.
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if ((valid || fail) && !seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
                check("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_valid",      {31'd0, valid},      {31'd0, e.valid});
                check("sb_fail",       {31'd0, fail},       {31'd0, e.fail});
                check("sb_moves",      {14'd0, moves},      {14'd0, e.moves});
                check("sb_move_count", {29'd0, move_count}, {29'd0, e.mc});
                check("sb_retries",    {30'd0, retries},    {30'd0, e.retries});
            end
        end else if (!valid && !fail) begin
            seen = 1'b0;
        end
    end

    task automatic kick_start(input logic [1:0] m);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        check("rng_one_cycle_after_start", {31'd0, rng_gen}, 32'd1);
    endtask

    task automatic respond(input int d, input logic [17:0] p);
        repeat (d) @(negedge clk);
        {scr_idx6, scr_idx5, scr_idx4, scr_idx3, scr_idx2, scr_idx1} = p;
        scr_done = 1'b1;
        @(negedge clk);
        scr_done = 1'b0;
    endtask

    task automatic wait_rng(input int budget, output int cyc, output bit found);
        cyc = 0;
        found = 1'b0;
        while (cyc < budget && !found) begin
            @(negedge clk);
            cyc++;
            if (rng_gen) found = 1'b1;
        end
    endtask

    task automatic wait_flag(input int budget, output int cyc, output int n_rng, output bit found);
        cyc = 0;
        n_rng = 0;
        found = 1'b0;
        while (cyc < budget && !found) begin
            @(negedge clk);
            cyc++;
            if (rng_gen) n_rng++;
            if (valid || fail) found = 1'b1;
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("ack_valid_clear", {31'd0, valid}, 32'd0);
        check("ack_fail_clear",  {31'd0, fail},  32'd0);
        check("ack_idle",        {31'd0, busy},  32'd0);
    endtask

    initial begin
        int cyc, n_rng;
        bit found;

        // Power-on reset.
        repeat (2) @(negedge clk);
        check("rst_busy",  {31'd0, busy},    32'd0);
        check("rst_rng",   {31'd0, rng_gen}, 32'd0);
        check("rst_valid", {31'd0, valid},   32'd0);
        check("rst_moves", {14'd0, moves},   32'd0);
        rst = 1'b0;

        // Reset while waiting for the datapath.
        kick_start(2'd3);
        repeat (3) @(negedge clk);
        check("wait_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        n_rng = 0;
        repeat (2) begin
            @(negedge clk);
            if (rng_gen) n_rng++;
        end
        rst = 1'b0;
        check("rst_mid_no_rng", n_rng, 0);
        check("rst_mid_busy",   {31'd0, busy},       32'd0);
        check("rst_mid_valid",  {31'd0, valid},      32'd0);
        check("rst_mid_fail",   {31'd0, fail},       32'd0);
        check("rst_mid_mode",   {30'd0, scr_mode},   32'd0);
        check("rst_mid_mc",     {29'd0, move_count}, 32'd0);
        check("rst_mid_retry",  {30'd0, retries},    32'd0);
        n_rng = 0;
        repeat (5) begin
            @(negedge clk);
            if (rng_gen || busy) n_rng++;
        end
        check("rst_mid_stays_idle", n_rng, 0);

        // Nominal: mode 10, idx6=7 unused.
        push_exp(1'b1, 1'b0, {3'd0, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, 3'd5, 2'd0);
        kick_start(2'd2);
        respond(5, {3'd7, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1});
        check("nom_check_cycle_valid", {31'd0, valid}, 32'd0);
        check("nom_check_cycle_busy",  {31'd0, busy},  32'd1);
        @(negedge clk);
        check("nom_valid_latency", {31'd0, valid},    32'd1);
        check("nom_scr_mode",      {30'd0, scr_mode}, 32'd2);
        start = 1'b1;
        n_rng = 0;
        repeat (4) begin
            @(negedge clk);
            if (rng_gen || busy) n_rng++;
        end
        start = 1'b0;
        check("result_start_ignored", n_rng, 0);
        check("result_valid_held", {31'd0, valid}, 32'd1);
        do_ack();

        // Illegal idx3=6 then a legal retry; mode change while busy ignored.
        push_exp(1'b1, 1'b0, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 3'd6, 2'd1);
        kick_start(2'd3);
        mode = 2'd0;
        respond(2, {3'd5, 3'd4, 3'd3, 3'd6, 3'd2, 3'd1});
        wait_rng(10, cyc, found);
        check("illegal_second_rng", {31'd0, found},    32'd1);
        check("illegal_retries",    {30'd0, retries},  32'd1);
        check("busy_mode_held",     {30'd0, scr_mode}, 32'd3);
        respond(3, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
        wait_flag(10, cyc, n_rng, found);
        check("illegal_result_seen", {31'd0, found}, 32'd1);
        do_ack();

        // Adjacent repeat 2,2,4 in mode 00.
`ifdef SCR_SEQ_ADJ_CHECK_EN
        push_exp(1'b1, 1'b0, {9'd0, 3'd4, 3'd3, 3'd2}, 3'd3, 2'd1);
        kick_start(2'd0);
        respond(1, {3'd1, 3'd6, 3'd7, 3'd4, 3'd2, 3'd2});
        wait_rng(10, cyc, found);
        check("adj_retry_rng", {31'd0, found}, 32'd1);
        respond(1, {3'd7, 3'd7, 3'd7, 3'd4, 3'd3, 3'd2});
`else
        push_exp(1'b1, 1'b0, {9'd0, 3'd4, 3'd2, 3'd2}, 3'd3, 2'd0);
        kick_start(2'd0);
        respond(1, {3'd1, 3'd6, 3'd7, 3'd4, 3'd2, 3'd2});
`endif
        wait_flag(10, cyc, n_rng, found);
        check("adj_result_seen", {31'd0, found}, 32'd1);
        check("adj_no_extra_rng", n_rng, 0);
        do_ack();

        // scr_done on the timeout-expiry cycle wins.
        push_exp(1'b1, 1'b0, {9'd0, 3'd3, 3'd1, 3'd0}, 3'd3, 2'd0);
        kick_start(2'd0);
        respond(256, {3'd7, 3'd7, 3'd7, 3'd3, 3'd1, 3'd0});
        check("coinc_in_check_no_rng", {31'd0, rng_gen}, 32'd0);
        check("coinc_in_check_busy",   {31'd0, busy},    32'd1);
        @(negedge clk);
        check("coinc_valid", {31'd0, valid}, 32'd1);
        do_ack();

        // Timeout exhaustion: four kicks 257 cycles apart, then fail.
        push_exp(1'b0, 1'b1, 18'd0, 3'd4, 2'd3);
        kick_start(2'd1);
        for (int p = 1; p <= 3; p++) begin
            wait_rng(400, cyc, found);
            check("to_rng_found",   {31'd0, found},   32'd1);
            check("to_rng_spacing", cyc,              257);
            check("to_retries",     {30'd0, retries}, p);
        end
        wait_flag(400, cyc, n_rng, found);
        check("to_fail_found",   {31'd0, found}, 32'd1);
        check("to_fail_latency", cyc,   257);
        check("to_no_fifth_rng", n_rng, 0);
        do_ack();

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule

// File: doc/scramble_sequencer.md
Name: scramble_sequencer

Overview:
- Controller that sequences the scrambler datapath (RNG → mod_top → scrambler_done) for one scramble request.
- On `start`: latches `mode`, pulses `rng_gen`, then waits for `scr_done` under a timeout.
- Captures the six indices and validates them; retries on bad or missing results.
- Publishes the accepted move list with a `valid`/`ack` handshake toward display/game logic.

Parameters:
- TIMEOUT_CYC, 255, cycles waited in WAIT for `scr_done` before counting a timeout (8-bit counter).
- MAX_RETRY, 3, additional attempts after the first before declaring failure.
- NUM_FACES, 6, legal index values are 0..NUM_FACES-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a scramble; sampled only in IDLE
- mode  input  2  requested scramble mode
- ack  input  1  consumer accepted result; clears valid/fail
- scr_done  input  1  scrambler datapath finished
- scr_idx1..scr_idx6  input  3 each  indices from scrambler datapath
- rng_gen  output  1  one-cycle kick to scrambler RNG
- scr_mode  output  2  mode held stable toward datapath while busy
- busy  output  1  high in KICK/WAIT/CHECK
- valid  output  1  accepted move list available
- fail  output  1  retries exhausted
- moves  output  18  packed result, idx1 in [2:0] … idx6 in [17:15]
- move_count  output  3  number of meaningful moves: mode 00→3, 01→4, 10→5, 11→6
- retries  output  2  attempts consumed beyond the first for the current result

Behaviour:
- Reset (rst=1 at a clock edge, any state):
  - state=IDLE.
  - rng_gen, busy, valid, fail = 0.
  - moves = 0, move_count = 0, retries = 0, scr_mode = 00.
  - Timeout counter cleared.
  - Mid-operation reset discards the attempt; no rng_gen is issued in the reset cycle.
- IDLE:
  - start=1 → latch mode into scr_mode, compute move_count, retries=0 → KICK.
  - start is ignored in IDLE while valid or fail is high; ack is required first.
- KICK:
  - rng_gen=1 for exactly this one cycle; clear timeout counter → WAIT.
- WAIT:
  - scr_done=1 → register scr_idx1..6 into a capture register → CHECK.
  - Counter reaches TIMEOUT_CYC without scr_done → retry path.
  - scr_done present in the same cycle the timeout expires: scr_done wins.
- CHECK (one cycle):
  - Only the first move_count indices are checked; unused slots in moves are forced to 0.
  - Every used index must be < NUM_FACES (6 and 7 are illegal).
  - Pass → moves=capture, valid=1 → RESULT.
  - Fail → retry path.
- Retry path:
  - retries < MAX_RETRY → retries+1 → KICK.
  - Otherwise fail=1, moves=0 → RESULT.
- RESULT:
  - Hold valid/fail, moves and retries stable.
  - ack=1 → clear valid/fail → IDLE. retries and moves hold until the next start.
  - start during RESULT is ignored.
- Latency, best case: start@T0 → KICK@T1 (rng_gen high) → WAIT from T2.
  - scr_done sampled @Tn → CHECK@Tn+1 → valid high from Tn+2.
- scr_mode stays constant from KICK through RESULT; mode changes while busy are ignored.
- retries saturates at MAX_RETRY and never wraps.

Optional Feature:
- Macro SCR_SEQ_ADJ_CHECK_EN.
- Defined: CHECK additionally rejects any adjacent equal pair among the used indices (idx k == idx k+1). Such a result takes the retry path.
- Undefined: only the range check applies; adjacent repeats are accepted.

Decomposition:
- Shared package scr_pkg holds:
  - State encoding: IDLE, KICK, WAIT, CHECK, RESULT.
  - NUM_FACES constant.
  - Mode→move_count mapping function.
  - IDX_W=3 constant.
- One combinational sub-module, scr_seq_checker:
  - Inputs: capture register and move_count.
  - Output: ok.
  - Holds the range check and the SCR_SEQ_ADJ_CHECK_EN-guarded adjacency check.

Test Plan:
- Reset: hold rst=1 for 2 cycles while in WAIT → next cycle state IDLE, all outputs 0, no rng_gen pulse.
- Nominal: mode=10, start; scr_done 5 cycles after rng_gen with idx=1,2,3,4,5,7 → move_count=5, moves[14:0] packs 1..5, moves[17:15]=0, valid=1, retries=0. idx6=7 is unused, so it is not illegal.
- Illegal index then recovery: mode=11, first result idx3=6 → second rng_gen pulse, retries=1. Second result legal → valid=1.
- Timeout exhaustion: never assert scr_done, MAX_RETRY=3 → exactly 4 rng_gen pulses, each 256 cycles apart plus KICK overhead → fail=1, moves=0.
- Adjacency: idx=2,2,4 with mode=00 → retry when SCR_SEQ_ADJ_CHECK_EN is defined, valid=1 when undefined.
- Handshake: start held during RESULT → ignored. ack → IDLE next cycle. scr_done coincident with timeout expiry → CHECK taken.
